// File: rtl/draw_pair_writer.sv
// pair_fifo: generic small FIFO with synchronous flush; the head entry is visible combinationally.
// Latency: an entry pushed at edge N can be popped at edge N+1.
// Backpressure: the caller gates push on count < DEPTH and pop on count != 0.
module pair_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// draw_pair_writer: validates {even,odd} pixel pairs and issues dual-port framebuffer writes for one draw job.
// Latency: a pair accepted at edge N is written (we_a/we_b high) after edge N+1 at the earliest.
// Backpressure: 2-entry FIFO; mem_ready low holds the head, in_ready drops when full or outside RUN.
module draw_pair_writer #(
    parameter int ADDR_W    = 14,
    parameter int COLOR_W   = 4,
    parameter int MEM_DEPTH = 16384,
    parameter int END_ADDR  = 14593
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  addr_a,
    input  logic [ADDR_W-1:0]  addr_b,
    input  logic [COLOR_W-1:0] color,
    input  logic               mem_ready,
    output logic               we_a,
    output logic               we_b,
    output logic [ADDR_W-1:0]  wr_addr_a,
    output logic [ADDR_W-1:0]  wr_addr_b,
    output logic [COLOR_W-1:0] wr_data_a,
    output logic [COLOR_W-1:0] wr_data_b,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pix_count,
    output logic [7:0]         err_count
);
    typedef struct packed {
        logic [ADDR_W-1:0]  addr_a;
        logic [ADDR_W-1:0]  addr_b;
        logic [COLOR_W-1:0] color;
    } pair_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int PAIR_W = $bits(pair_t);
    localparam logic [ADDR_W-1:0] END_B = ADDR_W'(END_ADDR);

    state_t      state;
    state_t      state_nx;
    pair_t       in_pair;
    pair_t       head;
    logic [1:0]  fifo_count;
    logic [1:0]  count_nx;
    logic        push_vld;
    logic        pop_vld;
    logic        pair_ok;
    logic        final_pair;
    logic [ADDR_W:0] succ_a;

    assign in_pair  = '{addr_a: addr_a, addr_b: addr_b, color: color};
    assign push_vld = in_valid && in_ready;
    assign pop_vld  = (state == S_RUN) && (fifo_count != 2'd0) && mem_ready;

    // Extra bit on the successor so an odd address at the top of the range cannot wrap to a match.
    assign succ_a     = {1'b0, head.addr_a} + 1'b1;
    assign pair_ok    = !head.addr_a[0]
                        && (succ_a == {1'b0, head.addr_b})
                        && (32'(head.addr_b) < 32'(MEM_DEPTH));
    assign final_pair = pop_vld && pair_ok && (head.addr_b == END_B);

    pair_fifo #(
        .W     (PAIR_W),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .arst_n   (reset),
        .flush    (final_pair),
        .push     (push_vld),
        .push_dat (in_pair),
        .pop      (pop_vld),
        .head_dat (head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (final_pair) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // in_ready is registered from next-cycle occupancy, so a full FIFO never advertises space.
    always_comb begin
        count_nx = fifo_count;
        if (final_pair)                count_nx = 2'd0;
        else if (push_vld && !pop_vld) count_nx = fifo_count + 2'd1;
        else if (pop_vld && !push_vld) count_nx = fifo_count - 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (state_nx == S_RUN) && (count_nx < 2'd2);
            busy     <= (state_nx == S_RUN);
            done     <= (state_nx == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_a      <= 1'b0;
            we_b      <= 1'b0;
            wr_addr_a <= '0;
            wr_addr_b <= '0;
            wr_data_a <= '0;
            wr_data_b <= '0;
        end else begin
            we_a <= 1'b0;
            we_b <= 1'b0;
            if (pop_vld && pair_ok) begin
                we_a      <= 1'b1;
                we_b      <= 1'b1;
                wr_addr_a <= head.addr_a;
                wr_addr_b <= head.addr_b;
                wr_data_a <= head.color;
                wr_data_b <= head.color;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_count <= '0;
            err_count <= '0;
        end else if ((state != S_RUN) && (state_nx == S_RUN)) begin
            pix_count <= '0;
            err_count <= '0;
        end else if (pop_vld) begin
            if (pair_ok)                 pix_count <= pix_count + 16'd2;
            else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_draw_pair_writer.sv
// Directed bench for draw_pair_writer: vector table for pair validation plus hand-written multi-cycle sequences.
module tb_draw_pair_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] addr_a;
    logic [13:0] addr_b;
    logic [3:0]  color;
    logic        mem_ready;
    logic        we_a;
    logic        we_b;
    logic [13:0] wr_addr_a;
    logic [13:0] wr_addr_b;
    logic [3:0]  wr_data_a;
    logic [3:0]  wr_data_b;
    logic        busy;
    logic        done;
    logic [15:0] pix_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int we_mismatch = 0;
    logic [13:0] wq_a[$];
    logic [13:0] wq_b[$];
    logic [3:0]  wq_d[$];

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [3:0]  c;
        logic        ok;
    } vec_t;
    vec_t vecs[8];

    draw_pair_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .color     (color),
        .mem_ready (mem_ready),
        .we_a      (we_a),
        .we_b      (we_b),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_data_a (wr_data_a),
        .wr_data_b (wr_data_b),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Write monitor: one record per cycle with the enables high.
    always @(negedge clk) begin
        if (we_a || we_b) begin
            if (we_a != we_b || wr_data_a != wr_data_b) we_mismatch++;
            wq_a.push_back(wr_addr_a);
            wq_b.push_back(wr_addr_b);
            wq_d.push_back(wr_data_a);
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] a, input logic [13:0] b, input logic [3:0] c);
        int waited = 0;
        in_valid = 1'b1;
        addr_a   = a;
        addr_b   = b;
        color    = c;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("send_ready", int'(in_ready), 1);
        if (in_ready) tick();
        in_valid = 1'b0;
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_we"}, int'(we_a) + int'(we_b), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pix"}, int'(pix_count), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_wr_addr"}, int'(wr_addr_a) + int'(wr_addr_b), 0);
        check({tag, "_wr_data"}, int'(wr_data_a) + int'(wr_data_b), 0);
    endtask

    initial begin
        int exp_pix;
        int exp_err;
        int base;
        int order_err;
        int snap;

        vecs[0] = '{14'd14337, 14'd14338, 4'h5, 1'b0};  // odd even-port address
        vecs[1] = '{14'd100,   14'd102,   4'h1, 1'b0};  // not adjacent
        vecs[2] = '{14'd16383, 14'd0,     4'h2, 1'b0};  // 16384 truncated to 14 bits
        vecs[3] = '{14'd200,   14'd201,   4'h7, 1'b1};
        vecs[4] = '{14'd16382, 14'd16383, 4'hF, 1'b1};  // top of the framebuffer
        vecs[5] = '{14'd14590, 14'd14593, 4'h4, 1'b0};  // bad pair ending at END_ADDR
        vecs[6] = '{14'd0,     14'd1,     4'h9, 1'b1};
        vecs[7] = '{14'd14591, 14'd14592, 4'h6, 1'b0};

        start = 1'b0; in_valid = 1'b0; addr_a = '0; addr_b = '0; color = '0; mem_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        reset = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        // Single pair: written one edge after acceptance.
        mem_ready = 1'b1;
        start_job();
        check("start_busy", int'(busy), 1);
        check("start_in_ready", int'(in_ready), 1);
        send(14'd14336, 14'd14337, 4'h3);
        check("lat_not_yet", int'(we_a), 0);
        tick();
        check("t1_we_a", int'(we_a), 1);
        check("t1_we_b", int'(we_b), 1);
        check("t1_addr_a", int'(wr_addr_a), 14336);
        check("t1_addr_b", int'(wr_addr_b), 14337);
        check("t1_data_a", int'(wr_data_a), 3);
        check("t1_data_b", int'(wr_data_b), 3);
        check("t1_pix", int'(pix_count), 2);
        tick();
        check("t1_pulse_end", int'(we_a), 0);
        check("t1_addr_hold", int'(wr_addr_a), 14336);
        exp_pix = 2;
        exp_err = 0;

        // Validation table.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c);
            tick();
            if (vecs[i].ok) exp_pix += 2;
            else            exp_err += 1;
            check($sformatf("vec%0d_we", i), int'(we_a), int'(vecs[i].ok));
            check($sformatf("vec%0d_pix", i), int'(pix_count), exp_pix);
            check($sformatf("vec%0d_err", i), int'(err_count), exp_err);
        end
        check("bad_end_no_done", int'(busy), 1);

        // Final pair ends the job.
        send(14'd14592, 14'd14593, 4'h1);
        tick();
        check("fin_we", int'(we_a), 1);
        check("fin_done", int'(done), 1);
        check("fin_busy", int'(busy), 0);
        check("fin_in_ready", int'(in_ready), 0);

        // Full-job stream of 129 pairs.
        start_job();
        check("restart_pix", int'(pix_count), 0);
        check("restart_err", int'(err_count), 0);
        check("restart_done", int'(done), 0);
        base = wq_a.size();
        for (int i = 0; i < 129; i++) send(14'(14336 + 2 * i), 14'(14337 + 2 * i), 4'(i));
        tick();
        tick();
        tick();
        check("stream_writes", wq_a.size() - base, 129);
        order_err = 0;
        for (int i = 0; i < 129 && base + i < wq_a.size(); i++) begin
            if (wq_a[base + i] != 14'(14336 + 2 * i) || wq_b[base + i] != 14'(14337 + 2 * i)
                || wq_d[base + i] != 4'(i)) order_err++;
        end
        check("stream_order", order_err, 0);
        check("stream_pix", int'(pix_count), 258);
        check("stream_done", int'(done), 1);
        check("stream_busy", int'(busy), 0);
        check("stream_in_ready", int'(in_ready), 0);

        // Back-pressure: three pairs against a stalled memory.
        start_job();
        base = wq_a.size();
        mem_ready = 1'b0;
        in_valid = 1'b1; addr_a = 14'd0; addr_b = 14'd1; color = 4'h1;
        tick();
        check("bp_rdy_after1", int'(in_ready), 1);
        addr_a = 14'd2; addr_b = 14'd3; color = 4'h2;
        tick();
        check("bp_rdy_after2", int'(in_ready), 0);
        addr_a = 14'd4; addr_b = 14'd5; color = 4'h3;
        tick();
        tick();
        tick();
        check("bp_rdy_held", int'(in_ready), 0);
        check("bp_no_write", wq_a.size() - base, 0);
        mem_ready = 1'b1;
        tick();
        check("bp_w0_we", int'(we_a), 1);
        check("bp_w0_addr", int'(wr_addr_a), 0);
        check("bp_rdy_back", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_w1_addr", int'(wr_addr_a), 2);
        check("bp_pushpop_rdy", int'(in_ready), 1);
        tick();
        check("bp_w2_we", int'(we_a), 1);
        check("bp_w2_addr", int'(wr_addr_a), 4);
        check("bp_w2_data", int'(wr_data_a), 3);
        tick();
        check("bp_writes", wq_a.size() - base, 3);
        check("bp_pix", int'(pix_count), 6);

        // start while running is ignored.
        start_job();
        check("run_start_busy", int'(busy), 1);
        check("run_start_pix", int'(pix_count), 6);

        // Error counter saturation.
        base = wq_a.size();
        for (int i = 0; i < 300; i++) send(14'd1, 14'd2, 4'h0);
        tick();
        tick();
        check("sat_err", int'(err_count), 255);
        check("sat_pix", int'(pix_count), 6);
        check("sat_no_write", wq_a.size() - base, 0);

        // Reset mid-job with a full FIFO and a write in flight.
        mem_ready = 1'b0;
        send(14'd10, 14'd11, 4'h1);
        send(14'd12, 14'd13, 4'h2);
        check("rst_full", int'(in_ready), 0);
        mem_ready = 1'b1;
        tick();
        check("rst_inflight_we", int'(we_a), 1);
        reset = 1'b0;
        #1 check_all_zero("rst_mid");
        snap = wq_a.size();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("rst_no_write", wq_a.size() - snap, 0);
        check("rst_idle_busy", int'(busy), 0);
        check("rst_idle_rdy", int'(in_ready), 0);
        start_job();
        check("rst_restart_pix", int'(pix_count), 0);
        check("rst_restart_err", int'(err_count), 0);
        send(14'd20, 14'd22, 4'h0);
        tick();
        check("rst_err_from0", int'(err_count), 1);
        send(14'd20, 14'd21, 4'h5);
        tick();
        check("rst_pix_from0", int'(pix_count), 2);
        check("we_pair_consistent", we_mismatch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
